// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: serialises the core's instruction and data buses onto one memory port
package core_bus_arbiter_pkg;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  mreq,
  input  dbus_resp_t mresp
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  state_t state, stateNext;
  owner_t sel, selNext, last, lastNext;
  logic fwdAddrOk, fwdDataOk;
  // addr_ok only counts while the address phase is open; data_ok only once the address was accepted
  assign fwdAddrOk = (state == ADDR) && mresp.addr_ok;
  assign fwdDataOk = ((state == ADDR) && mresp.addr_ok && mresp.data_ok) || ((state == DATA) && mresp.data_ok);
  // state, owner and previous-grant registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= OWN_I;
      last  <= OWN_I;
    end else begin
      state <= stateNext;
      sel   <= selNext;
      last  <= lastNext;
    end
  end
  // grant decision in IDLE and phase tracking of the single outstanding transaction
  always_comb begin
    stateNext = state;
    selNext   = sel;
    lastNext  = last;
    case (state)
      IDLE: begin
        if (dreq.valid && (!ireq.valid || !RR_ENABLE || last == OWN_I)) begin
          selNext   = OWN_D;
          stateNext = ADDR;
        end else if (ireq.valid) begin
          selNext   = OWN_I;
          stateNext = ADDR;
        end
      end
      ADDR: begin
        if (mresp.addr_ok) begin
          stateNext = mresp.data_ok ? IDLE : DATA;
          lastNext  = mresp.data_ok ? sel : last;
        end
      end
      DATA: begin
        if (mresp.data_ok) begin
          stateNext = IDLE;
          lastNext  = sel;
        end
      end
      default: stateNext = IDLE;
    endcase
  end
  // memory request from the owner during ADDR; responses steered to the owner only
  always_comb begin
    mreq  = '0;
    iresp = '0;
    dresp = '0;
    if (state == ADDR) begin
      if (sel == OWN_D) mreq = dreq;
      else begin
        mreq.valid = ireq.valid;
        mreq.addr  = ireq.addr;
        mreq.size  = MSIZE4;
      end
    end
    if (sel == OWN_I) begin
      iresp.addr_ok = fwdAddrOk;
      iresp.data_ok = fwdDataOk;
      iresp.data    = fwdDataOk ? mresp.data : '0;
    end else begin
      dresp.addr_ok = fwdAddrOk;
      dresp.data_ok = fwdDataOk;
      dresp.data    = fwdDataOk ? mresp.data : '0;
    end
  end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed checks of the two-master bus arbiter
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset;
  ibus_req_t ireq;
  ibus_resp_t iresp, iresp0;
  dbus_req_t dreq, mreq, mreq0, expReq;
  dbus_resp_t dresp, dresp0, mresp;
  int tests = 0;
  int fails = 0;

  core_bus_arbiter #(.RR_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp), .dreq(dreq),
    .dresp(dresp), .mreq(mreq), .mresp(mresp)
  );
  core_bus_arbiter #(.RR_ENABLE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp0), .dreq(dreq),
    .dresp(dresp0), .mreq(mreq0), .mresp(mresp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    ireq  = '0;
    dreq  = '0;
    mresp = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    quiet();
    ireq = '{valid: 1'b1, addr: 32'hBFC0_0000};
    #1;
    tests++;
    if ({mreq, iresp, dresp} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got mreq=%h iresp=%h dresp=%h want 0", mreq, iresp, dresp);
    end
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({mreq, iresp, dresp} !== '0) begin
      fails++;
      $display("FAIL reset_release_cycle: got mreq=%h iresp=%h dresp=%h want 0", mreq, iresp, dresp);
    end
    ireq = '0;
    tick();
    tests++;
    if (mreq.valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got mreq.valid=%b want 0", mreq.valid);
    end
  endtask

  task automatic test_fetch;
    ireq = '{valid: 1'b1, addr: 32'hBFC0_0000};
    #1;
    tests++;
    if (mreq.valid !== 1'b0) begin
      fails++;
      $display("FAIL fetch_no_comb_grant: got mreq.valid=%b want 0", mreq.valid);
    end
    tick();
    expReq = '{valid: 1'b1, addr: 32'hBFC0_0000, size: MSIZE4, strobe: 4'h0, data: 32'h0};
    tests++;
    if (mreq !== expReq) begin
      fails++;
      $display("FAIL fetch_mreq: got %h want %h", mreq, expReq);
    end
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h2408_0001};
    #1;
    tests++;
    if (iresp !== 66'h3_2408_0001) begin
      fails++;
      $display("FAIL fetch_iresp: got %h want 3_24080001", iresp);
    end
    tests++;
    if (dresp !== '0) begin
      fails++;
      $display("FAIL fetch_dresp_quiet: got %h want 0", dresp);
    end
    tick();
    ireq  = '0;
    mresp = '0;
    #1;
    tests++;
    if ({mreq.valid, iresp} !== '0) begin
      fails++;
      $display("FAIL fetch_back_idle: got valid=%b iresp=%h want 0", mreq.valid, iresp);
    end
    tick();
  endtask

  task automatic test_data_read;
    dreq = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE4, strobe: 4'h0, data: 32'h0};
    tick();
    tests++;
    if (mreq !== dreq || dresp.addr_ok !== 1'b0) begin
      fails++;
      $display("FAIL read_c1: got mreq=%h addr_ok=%b want mreq=%h addr_ok=0", mreq, dresp.addr_ok, dreq);
    end
    tick();
    mresp.addr_ok = 1'b1;
    #1;
    tests++;
    if (dresp.addr_ok !== 1'b1 || dresp.data_ok !== 1'b0 || iresp !== '0) begin
      fails++;
      $display("FAIL read_c2: got dresp=%h iresp=%h want addr_ok only", dresp, iresp);
    end
    tick();
    dreq  = '0;
    mresp = '0;
    #1;
    tests++;
    if (mreq.valid !== 1'b0 || dresp !== '0) begin
      fails++;
      $display("FAIL read_c3: got valid=%b dresp=%h want 0", mreq.valid, dresp);
    end
    tick();
    mresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'hDEAD_BEEF};
    #1;
    tests++;
    if (dresp !== 66'h1_DEAD_BEEF || iresp !== '0) begin
      fails++;
      $display("FAIL read_c4: got dresp=%h iresp=%h want 1_deadbeef / 0", dresp, iresp);
    end
    tick();
    mresp = '0;
    #1;
    tests++;
    if ({mreq, iresp, dresp} !== '0) begin
      fails++;
      $display("FAIL read_c5: got mreq=%h dresp=%h want 0", mreq, dresp);
    end
  endtask

  task automatic test_write;
    dreq = '{valid: 1'b1, addr: 32'h8000_0004, size: MSIZE2, strobe: 4'b0011, data: 32'h0000_1234};
    expReq = '{valid: 1'b1, addr: 32'h8000_0004, size: MSIZE2, strobe: 4'b0011, data: 32'h0000_1234};
    tick();
    tests++;
    if (mreq !== expReq) begin
      fails++;
      $display("FAIL write_mreq: got %h want %h", mreq, expReq);
    end
    tick();
    tests++;
    if (mreq !== expReq) begin
      fails++;
      $display("FAIL write_mreq_held: got %h want %h", mreq, expReq);
    end
    mresp.addr_ok = 1'b1;
    #1;
    tests++;
    if (dresp.addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL write_addr_ok: got %b want 1", dresp.addr_ok);
    end
    tick();
    dreq  = '0;
    mresp = '0;
    #1;
    tests++;
    if (dresp.data_ok !== 1'b0 || dresp.addr_ok !== 1'b0 || mreq.valid !== 1'b0) begin
      fails++;
      $display("FAIL write_data_wait: got dresp=%h valid=%b want 0", dresp, mreq.valid);
    end
    mresp.data_ok = 1'b1;
    #1;
    tests++;
    if (dresp.data_ok !== 1'b1) begin
      fails++;
      $display("FAIL write_data_ok: got %b want 1", dresp.data_ok);
    end
    tick();
    #1;
    tests++;
    if (dresp.data_ok !== 1'b0) begin
      fails++;
      $display("FAIL write_single_data_ok: got %b want 0", dresp.data_ok);
    end
    mresp = '0;
    tick();
  endtask

  task automatic test_back_to_back;
    reset = 1'b1;
    ireq  = '{valid: 1'b1, addr: 32'hBFC0_0100};
    dreq  = '{valid: 1'b1, addr: 32'h8000_0200, size: MSIZE4, strobe: 4'h0, data: 32'h0};
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h1111_2222};
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({mreq, iresp, dresp, mreq0, iresp0, dresp0} !== '0) begin
      fails++;
      $display("FAIL rr_release_quiet: got mreq=%h iresp=%h dresp=%h want 0", mreq, iresp, dresp);
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      tests++;
      if (mreq.addr !== ((g % 2 == 1) ? 32'hBFC0_0100 : 32'h8000_0200) || mreq.valid !== 1'b1) begin
        fails++;
        $display("FAIL rr_grant%0d: got valid=%b addr=%h", g, mreq.valid, mreq.addr);
      end
      tests++;
      if (iresp.addr_ok !== (g % 2 == 1) || dresp.addr_ok !== (g % 2 == 0)) begin
        fails++;
        $display("FAIL rr_owner%0d: got iresp.addr_ok=%b dresp.addr_ok=%b", g, iresp.addr_ok, dresp.addr_ok);
      end
      tests++;
      if (mreq0.addr !== 32'h8000_0200 || dresp0.data_ok !== 1'b1 || iresp0 !== '0) begin
        fails++;
        $display("FAIL fixed_grant%0d: got addr=%h data_ok=%b iresp=%h want D", g, mreq0.addr, dresp0.data_ok, iresp0);
      end
      tick();
      tests++;
      if (mreq.valid !== 1'b0 || {iresp, dresp} !== '0) begin
        fails++;
        $display("FAIL rr_gap%0d: got valid=%b iresp=%h dresp=%h want 0", g, mreq.valid, iresp, dresp);
      end
    end
    quiet();
    tick();
  endtask

  task automatic test_reset_in_data;
    dreq = '{valid: 1'b1, addr: 32'h8000_0040, size: MSIZE4, strobe: 4'h0, data: 32'h0};
    tick();
    mresp.addr_ok = 1'b1;
    tick();
    dreq  = '0;
    mresp = '0;
    #1;
    tests++;
    if (mreq.valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_data_phase: got valid=%b want 0", mreq.valid);
    end
    mresp.data_ok = 1'b1;
    mresp.data    = 32'hCAFE_F00D;
    reset = 1'b1;
    #1;
    tests++;
    if ({mreq, iresp, dresp} !== '0) begin
      fails++;
      $display("FAIL rst_immediate: got mreq=%h dresp=%h want 0", mreq, dresp);
    end
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({iresp, dresp} !== '0) begin
      fails++;
      $display("FAIL rst_late_data_ok: got iresp=%h dresp=%h want 0", iresp, dresp);
    end
    mresp = '0;
    ireq  = '{valid: 1'b1, addr: 32'hBFC0_0380};
    tick();
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0000_0042};
    #1;
    tests++;
    if (mreq.addr !== 32'hBFC0_0380 || mreq.valid !== 1'b1 || iresp !== 66'h3_0000_0042) begin
      fails++;
      $display("FAIL rst_regrant: got valid=%b addr=%h iresp=%h", mreq.valid, mreq.addr, iresp);
    end
    tick();
    quiet();
    tick();
  endtask

  task automatic test_stray;
    quiet();
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hFFFF_FFFF};
    #1;
    tests++;
    if ({iresp, dresp, mreq} !== '0) begin
      fails++;
      $display("FAIL stray_now: got iresp=%h dresp=%h mreq=%h want 0", iresp, dresp, mreq);
    end
    tick();
    tests++;
    if ({iresp, dresp, mreq} !== '0) begin
      fails++;
      $display("FAIL stray_next: got iresp=%h dresp=%h mreq=%h want 0", iresp, dresp, mreq);
    end
    mresp = '0;
    dreq  = '{valid: 1'b1, addr: 32'h8000_0080, size: MSIZE4, strobe: 4'h0, data: 32'h0};
    tick();
    tests++;
    if (mreq.valid !== 1'b1 || mreq.addr !== 32'h8000_0080) begin
      fails++;
      $display("FAIL stray_still_idle: got valid=%b addr=%h want 1/80000080", mreq.valid, mreq.addr);
    end
    quiet();
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0};
    tick();
    mresp = '0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_read();
    test_write();
    test_back_to_back();
    test_reset_in_data();
    test_stray();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
